// File: rtl/simplerisc_imm_pkg.sv
// Shared constants and types for the SimpleRISC immediate / branch-target generator.
//   - Modifier encodings carried in instr[17:16].
//   - Field positions of the immediate, modifier and branch offset.
//   - Packed result entry {pc, immx, target} at the default 32-bit XLEN.
package simplerisc_imm_pkg;

  localparam logic [1:0] MOD_DEF = 2'b00;
  localparam logic [1:0] MOD_U   = 2'b01;
  localparam logic [1:0] MOD_H   = 2'b10;

  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned MOD_LSB = 16;
  localparam int unsigned MOD_MSB = 17;
  localparam int unsigned OFF_MSB = 26;

  localparam int unsigned XLEN_DEF = 32;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] immx;
    logic [XLEN_DEF-1:0] target;
  } imm_entry_t;

endpackage

// File: rtl/imm_branch_gen_pipe_if.sv
// Handshake bundle between decode, the immediate generator and execute.
//   master: decode/execute side (drives in_*, flush, out_ready)
//   slave : generator side (drives in_ready, out_*)
interface imm_branch_gen_pipe_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_immx;
  logic [XLEN-1:0] out_branch_target;
  logic [XLEN-1:0] out_pc;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_immx, out_branch_target, out_pc
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_immx, out_branch_target, out_pc
  );
endinterface

// File: rtl/imm_skid_buf.sv
// Two-entry valid/ready skid buffer with synchronous flush.
//   i_wr_valid/o_wr_ready/i_wr_data : producer side
//   o_rd_valid/i_rd_ready/o_rd_data : consumer side, o_rd_data is always the head
//   i_flush : empties the buffer; a same-cycle write is dropped, a same-cycle read completes
module imm_skid_buf #(
  parameter int unsigned Width = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [Width-1:0] i_wr_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [Width-1:0] o_rd_data
);
  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_in_ready;
  logic [Width-1:0]   r_head;
  logic [Width-1:0]   r_tail;
  logic               w_wr;
  logic               w_rd;

  assign w_wr = i_wr_valid & r_in_ready & ~i_flush;
  assign w_rd = i_rd_ready & (r_state != StEmpty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StEmpty;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      // Registered ready, looked ahead from the next state.
      r_in_ready <= (w_state_nxt != StTwo);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: if (w_wr) w_state_nxt = StOne;
        StOne: begin
          if (w_wr && !w_rd)      w_state_nxt = StTwo;
          else if (!w_wr && w_rd) w_state_nxt = StEmpty;
        end
        StTwo:   if (w_rd) w_state_nxt = StOne;
        default: w_state_nxt = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      // Head takes the new entry when it is (or is becoming) the only one.
      if (w_wr && (r_state == StEmpty || (r_state == StOne && w_rd))) begin
        r_head <= i_wr_data;
      end else if (w_rd && r_state == StTwo) begin
        r_head <= r_tail;
      end
      if (w_wr && r_state == StOne && !w_rd) begin
        r_tail <= i_wr_data;
      end
    end
  end

  always_comb begin
    o_rd_valid = (r_state != StEmpty);
    o_wr_ready = r_in_ready;
  end

  assign o_rd_data = r_head;
endmodule

// File: rtl/imm_branch_gen_pipe.sv
// Pipelined SimpleRISC immediate and branch-target generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the decode/execute handshake bundle (inputs, flush, results)
// Decode is combinational on the input side; results plus the PC are queued in imm_skid_buf.
module imm_branch_gen_pipe
  import simplerisc_imm_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned OFF_SHIFT = 0,
  parameter int unsigned MOD_EN    = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  imm_branch_gen_pipe_if.slave bus
);
  localparam int unsigned EntryW = 3 * XLEN;

  logic [15:0]       w_imm;
  logic [1:0]        w_mod;
  logic [XLEN-1:0]   w_immx;
  logic [XLEN-1:0]   w_off;
  logic [XLEN-1:0]   w_target;
  logic [EntryW-1:0] w_wr_data;
  logic [EntryW-1:0] w_rd_data;
  logic              w_unused_bits;

  assign w_imm = bus.in_instr[IMM_MSB:IMM_LSB];
  assign w_mod = bus.in_instr[MOD_MSB:MOD_LSB];

  always_comb begin
    w_immx = '0;
    if (MOD_EN != 0) begin
      unique case (w_mod)
        MOD_U:   w_immx = XLEN'(w_imm);
        MOD_H:   w_immx = XLEN'({w_imm, 16'h0000});
        default: w_immx = XLEN'($signed(w_imm));  // MOD_DEF and reserved 2'b11
      endcase
    end else begin
      w_immx = XLEN'($signed(bus.in_instr[MOD_MSB:IMM_LSB]));
    end
  end

  assign w_off    = XLEN'($signed(bus.in_instr[OFF_MSB:0]));
  assign w_target = bus.in_pc + (w_off << OFF_SHIFT);

  assign w_wr_data     = {bus.in_pc, w_immx, w_target};
  assign w_unused_bits = ^bus.in_instr[31:OFF_MSB+1];

  imm_skid_buf #(
    .Width (EntryW)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (bus.flush),
    .i_wr_valid (bus.in_valid),
    .o_wr_ready (bus.in_ready),
    .i_wr_data  (w_wr_data),
    .o_rd_valid (bus.out_valid),
    .i_rd_ready (bus.out_ready),
    .o_rd_data  (w_rd_data)
  );

  assign bus.out_pc            = w_rd_data[3*XLEN-1:2*XLEN];
  assign bus.out_immx          = w_rd_data[2*XLEN-1:XLEN];
  assign bus.out_branch_target = w_rd_data[XLEN-1:0];
endmodule

// File: tb/tb_imm_branch_gen_pipe.sv
// Bench for imm_branch_gen_pipe: two instances share stimulus.
//   dut_a : OFF_SHIFT=2, MOD_EN=1      dut_b : OFF_SHIFT=0, MOD_EN=0
module tb_imm_branch_gen_pipe;
  import simplerisc_imm_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  imm_branch_gen_pipe_if #(.XLEN(32)) bus_a ();
  imm_branch_gen_pipe_if #(.XLEN(32)) bus_b ();

  imm_branch_gen_pipe #(.XLEN(32), .OFF_SHIFT(2), .MOD_EN(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  imm_branch_gen_pipe #(.XLEN(32), .OFF_SHIFT(0), .MOD_EN(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } txn_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] immx_a;
    logic [31:0] tgt_a;
    logic [31:0] immx_b;
    logic [31:0] tgt_b;
  } vec_t;

  txn_t q[$];

  // Reference: immediate from the modifier rules, plain integer arithmetic.
  function automatic logic [31:0] ref_imm(input logic [31:0] instr, input bit mod_en);
    longint v;
    int     m;
    m = int'(instr[17:16]);
    if (mod_en) begin
      v = longint'(instr[15:0]);
      if (m == 1) return 32'(v);
      if (m == 2) return 32'(v * 65536);
      if (v >= 32768) v = v - 65536;
      return 32'(v);
    end
    v = longint'(instr[17:0]);
    if (v >= 131072) v = v - 262144;
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_tgt(input logic [31:0] pc, input logic [31:0] instr,
                                          input int shift);
    longint off;
    longint p;
    off = longint'(instr[26:0]);
    if (off >= 67108864) off = off - 134217728;
    p = longint'(pc);
    return 32'(p + off * (longint'(1) << shift));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic fl, input logic ordy);
    bus_a.in_valid = v;   bus_b.in_valid = v;
    bus_a.in_pc    = pc;  bus_b.in_pc    = pc;
    bus_a.in_instr = instr; bus_b.in_instr = instr;
    bus_a.flush    = fl;  bus_b.flush    = fl;
    bus_a.out_ready = ordy; bus_b.out_ready = ordy;
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic fl, input logic ordy, output logic acc);
    logic rd;
    drive(v, pc, instr, fl, ordy);
    #1;
    chk("out_valid_a", 32'(bus_a.out_valid), 32'(q.size() != 0));
    chk("in_ready_a", 32'(bus_a.in_ready), 32'(q.size() < 2));
    chk("out_valid_b", 32'(bus_b.out_valid), 32'(q.size() != 0));
    chk("in_ready_b", 32'(bus_b.in_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      chk("head_pc_a", bus_a.out_pc, q[0].pc);
      chk("head_immx_a", bus_a.out_immx, ref_imm(q[0].instr, 1'b1));
      chk("head_tgt_a", bus_a.out_branch_target, ref_tgt(q[0].pc, q[0].instr, 2));
      chk("head_pc_b", bus_b.out_pc, q[0].pc);
      chk("head_immx_b", bus_b.out_immx, ref_imm(q[0].instr, 1'b0));
      chk("head_tgt_b", bus_b.out_branch_target, ref_tgt(q[0].pc, q[0].instr, 0));
    end
    acc = v && (q.size() < 2) && !fl;
    rd  = ordy && (q.size() != 0);
    @(posedge clk);
    if (rd) void'(q.pop_front());
    if (fl) q.delete();
    else if (acc) q.push_back('{pc: pc, instr: instr});
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus_a.out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(bus_a.in_ready), 32'd1);
    chk({tag, "_immx"}, bus_a.out_immx, 32'd0);
    chk({tag, "_tgt"}, bus_a.out_branch_target, 32'd0);
    chk({tag, "_pc"}, bus_a.out_pc, 32'd0);
    chk({tag, "_pc_b"}, bus_b.out_pc, 32'd0);
  endtask

  vec_t        vecs[7];
  logic [31:0] bp_pc[4];
  logic [31:0] bp_in[4];
  logic [31:0] seen[4];
  imm_entry_t  got;
  logic        acc;
  int          idx;
  int          nseen;
  int          ncyc;

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{32'h100, 32'h0000FFFF, 32'hFFFFFFFF, 32'h000400FC, 32'h0000FFFF, 32'h000100FF};
    vecs[1] = '{32'h200, 32'h0001FFFF, 32'h0000FFFF, 32'h000801FC, 32'h0001FFFF, 32'h000201FF};
    vecs[2] = '{32'h000, 32'h00021234, 32'h12340000, 32'h000848D0, 32'hFFFE1234, 32'h00021234};
    vecs[3] = '{32'h010, 32'h00038000, 32'hFFFF8000, 32'h000E0010, 32'hFFFF8000, 32'h00038010};
    vecs[4] = '{32'h100, 32'h07FFFFFF, 32'hFFFFFFFF, 32'h000000FC, 32'hFFFFFFFF, 32'h000000FF};
    vecs[5] = '{32'hFFFFFFFC, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000001,
                32'hFFFFFFFD};
    vecs[6] = '{32'h1000, 32'hFC000000, 32'h00000000, 32'hF0001000, 32'h00000000, 32'hFC001000};

    // Reset with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      @(negedge clk);
      #1 chk_reset_outputs("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);

    // Directed vectors, one at a time.
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].pc, vecs[i].instr, 1'b0, 1'b1, acc);
      #1;
      chk("vec_valid", 32'(bus_a.out_valid), 32'd1);
      got = '{pc: bus_a.out_pc, immx: bus_a.out_immx, target: bus_a.out_branch_target};
      chk("vec_pc", got.pc, vecs[i].pc);
      chk("vec_immx_a", got.immx, vecs[i].immx_a);
      chk("vec_tgt_a", got.target, vecs[i].tgt_a);
      chk("vec_immx_b", bus_b.out_immx, vecs[i].immx_b);
      chk("vec_tgt_b", bus_b.out_branch_target, vecs[i].tgt_b);
      @(negedge clk);
      cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);
    end

    // Backpressure: A-D offered while the consumer stalls.
    for (int i = 0; i < 4; i++) begin
      bp_pc[i] = 32'h4000 + 32'(i) * 4;
      bp_in[i] = $urandom;
    end
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, bp_pc[idx], bp_in[idx], 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    #1;
    chk("bp_in_ready_low", 32'(bus_a.in_ready), 32'd0);
    chk("bp_head_is_a", bus_a.out_pc, bp_pc[0]);
    @(negedge clk);
    nseen = 0;
    ncyc  = 0;
    while (nseen < 4 && ncyc < 12) begin
      if (bus_a.out_valid) begin
        seen[nseen] = bus_a.out_pc;
        nseen++;
      end
      cycle(idx < 4, bp_pc[idx % 4], bp_in[idx % 4], 1'b0, 1'b1, acc);
      if (acc) idx++;
      ncyc++;
    end
    chk("bp_count", 32'(nseen), 32'd4);
    chk("bp_cycles", 32'(ncyc), 32'd4);
    for (int i = 0; i < 4; i++) chk("bp_order", seen[i], bp_pc[i]);

    // Flush while full, with a write attempt and a read.
    cycle(1'b1, 32'h5000, $urandom, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h5004, $urandom, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h5008, $urandom, 1'b1, 1'b1, acc);
    #1;
    chk("flush_valid", 32'(bus_a.out_valid), 32'd0);
    chk("flush_ready", 32'(bus_a.in_ready), 32'd1);
    @(negedge clk);

    // Asynchronous reset mid-operation.
    cycle(1'b1, 32'h6000, $urandom, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'h6004, $urandom, 1'b0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
            1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0), acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imm_branch_gen_pipe.md
# imm_branch_gen_pipe

Parametrised, pipelined immediate and branch-target generator for the SimpleRISC decode stage. It is the registered successor of the combinational immediate generator. It decodes the 18-bit immediate with its SimpleRISC modifier bits (default, `u`, `h`) and computes the branch target at a configurable offset scale. Results pass through a 2-entry skid buffer with valid/ready handshakes, so the block can absorb execute-stage stalls and hazard-unit flushes without losing or duplicating instructions.

## Interface
- `XLEN`, 32: data and address width; must be at least 27.
- `OFF_SHIFT`, 0: left shift applied to the branch offset (0 for word-addressed, 2 for byte-addressed).
- `MOD_EN`, 1: 1 decodes modifier bits [17:16]; 0 always sign-extends all of instr[17:0].

Ports, clock and reset first:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  block can accept one instruction this cycle.
- `in_pc`  in  XLEN  PC of the instruction.
- `in_instr`  in  32  instruction word.
- `flush`  in  1  hazard-unit squash, synchronous.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_immx`  out  XLEN  decoded immediate.
- `out_branch_target`  out  XLEN  computed branch target.
- `out_pc`  out  XLEN  PC carried with the result.

## Operation
- Immediate decode when `MOD_EN`=1, using m = instr[17:16] and i = instr[15:0]:
  - m=00: sign-extend i to XLEN.
  - m=01 (`u`): zero-extend i.
  - m=10 (`h`): {i, 16'b0}, zero-extended to XLEN.
  - m=11: reserved; treated as m=00.
- Immediate decode when `MOD_EN`=0: sign-extend instr[17:0].
- Branch target = in_pc + (sign-extend instr[26:0] to XLEN) << OFF_SHIFT, truncated modulo 2^XLEN. Wrap-around is silent.
- Decode is combinational on the input side. Results, together with `in_pc`, are written into a 2-entry FIFO (skid buffer).
- A write happens when `in_valid` and `in_ready` are both high. A read happens when `out_valid` and `out_ready` are both high.
- Buffer states and transitions:
  - EMPTY -> ONE on a write.
  - ONE -> TWO on a write without a read.
  - ONE -> EMPTY on a read without a write.
  - ONE stays ONE on a simultaneous read and write.
  - TWO -> ONE on a read. No write is possible in TWO.
- `in_ready` = (state != TWO). It is registered, derived from the next state.
- `out_valid` = (state != EMPTY). Outputs always show the head entry.
- Flush, sampled at the clock edge, returns the block to EMPTY. Any write attempted in the same cycle is dropped, and any read in the same cycle completes normally, so the consumer sees the head entry once.
- Order is strictly FIFO. No entry is reordered or duplicated.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state = EMPTY, `out_valid`=0, `in_ready`=1.
  - `out_immx`, `out_branch_target` and `out_pc` = 0.
  - Both buffer entries are cleared.
- Latency: an instruction accepted at edge N is presented with `out_valid`=1 after edge N. That is 1 cycle.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- `out_ready` low for k cycles: at most 2 instructions are absorbed, then `in_ready` drops one cycle after the second accept.
- `in_ready` rises again in the cycle after the first read out of TWO.
- Reset asserted mid-operation: all entries are lost and outputs return to their reset values immediately, without waiting for a clock edge.
- Head outputs stay stable while `out_valid`=1 and `out_ready`=0.

## Structure
- Shared package `simplerisc_imm_pkg` holds:
  - the modifier constants `MOD_DEF`=2'b00, `MOD_U`=2'b01, `MOD_H`=2'b10;
  - the field positions IMM_LSB/MSB, MOD_LSB/MSB and OFF_MSB;
  - a packed entry struct {pc, immx, target}.
- Sub-module `imm_skid_buf`, parametrised by entry width, implements the 2-entry handshake buffer with flush.
- The top level contains only the combinational decode and the instantiation of `imm_skid_buf`.

## Test plan
1. Reset: hold `rst_n`=0 with random inputs. Required: `out_valid`=0, `in_ready`=1, all data outputs 0.
2. Modifiers, with XLEN=32, `MOD_EN`=1, `out_ready`=1:
   - instr[17:0]=0x0FFFF -> `out_immx`=0xFFFFFFFF.
   - instr[17:0]=0x1FFFF -> `out_immx`=0x0000FFFF.
   - instr[17:0]=0x21234 -> `out_immx`=0x12340000.
   - Each result appears one cycle after acceptance.
3. Branch targets, with `OFF_SHIFT`=2:
   - pc=0x100, off=0x7FFFFFF (that is, -1) -> target 0xFC.
   - pc=0xFFFFFFFC, off=1 -> target 0x00000000 (wrap-around).
4. Backpressure: stream 4 instructions A–D with `out_ready`=0. Required: A and B accepted, `in_ready`=0 after the second accept, C held. Then raise `out_ready`: outputs A, B, C, D appear in order with no gaps or duplicates.
5. Flush: with state TWO, assert `flush` together with `in_valid` and `out_ready`=1. Required: the head is consumed once, the new instruction is dropped, next cycle `out_valid`=0 and `in_ready`=1.
6. `MOD_EN`=0: instr[17:0]=0x21234 -> `out_immx`=0xFFFE1234.
